// File: rtl/sign_mag_combiner.sv
// sign_mag_combiner: rebuilds Wc two's-complement W-bit LLRs from sign/magnitude pairs, P lanes per cycle.
// Result valid Wc/P cycles after acceptance; held until out_ready, and a new frame may be accepted on the release cycle.
module sign_mag_combiner #(
  parameter int W  = 6,
  parameter int Wc = 18,
  parameter int P  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [Wc-1:0]       signL,
  input  logic [Wc*(W-1)-1:0] absL,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Wc*W-1:0]     L,
  output logic                nz_flag
);

  localparam int N  = Wc / P;
  localparam int M  = W - 1;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(N - 1);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [Wc-1:0]   r_sign;
  logic [Wc*M-1:0] r_abs;
  logic [Wc*W-1:0] r_L;
  logic [GW-1:0]   r_grp;
  logic            r_nz_acc;
  logic            r_nz;

  logic [Wc*W-1:0] w_conv;
  logic [Wc-1:0]   w_lane_nz;
  logic [N-1:0]    w_grp_nz;
  logic            w_sel_nz;
  logic            w_last;
  logic            w_capture;

  genvar gi;
  generate
    for (gi = 0; gi < Wc; gi++) begin : g_lane
      logic [W-1:0] w_ext;
      assign w_ext = {1'b0, r_abs[gi*M +: M]};
      // Negating a zero magnitude yields zero, so -0 collapses to +0 without a special case.
      assign w_conv[gi*W +: W] = r_sign[gi] ? (W'(0) - w_ext) : w_ext;
      assign w_lane_nz[gi]     = r_sign[gi] & ~(|r_abs[gi*M +: M]);
    end
    for (gi = 0; gi < N; gi++) begin : g_grp
      assign w_grp_nz[gi] = |w_lane_nz[gi*P +: P];
    end
  endgenerate

  always_comb begin
    w_sel_nz = 1'b0;
    for (int g = 0; g < N; g++) begin
      if (r_grp == GW'(g)) w_sel_nz = w_grp_nz[g];
    end
  end

  assign w_last = (r_grp == LAST_GRP);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) w_state_nxt = CONV;
      end
      CONV: begin
        if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready & rst;
        if (out_ready) w_state_nxt = in_valid ? CONV : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_capture = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign   <= '0;
      r_abs    <= '0;
      r_grp    <= '0;
      r_nz_acc <= 1'b0;
      r_nz     <= 1'b0;
    end else if (w_capture) begin
      r_sign   <= signL;
      r_abs    <= absL;
      r_grp    <= '0;
      r_nz_acc <= 1'b0;
    end else if (r_state == CONV) begin
      r_nz_acc <= r_nz_acc | w_sel_nz;
      if (w_last) begin
        r_grp <= '0;
        r_nz  <= r_nz_acc | w_sel_nz;
      end else begin
        r_grp <= r_grp + GW'(1);
      end
    end
  end

  // Only the addressed group is written, so earlier groups stay intact for the rest of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_L <= '0;
    end else if (r_state == CONV) begin
      for (int g = 0; g < N; g++) begin
        if (r_grp == GW'(g)) r_L[g*P*W +: P*W] <= w_conv[g*P*W +: P*W];
      end
    end
  end

  assign L       = r_L;
  assign nz_flag = r_nz;

endmodule

// File: tb/tb_sign_mag_combiner.sv
// Bench for sign_mag_combiner: directed steps with a frame scoreboard, default build plus a P=Wc build.
module tb_sign_mag_combiner;

  localparam int W  = 6;
  localparam int WC = 18;
  localparam int M  = W - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, nz_flag;
  logic [WC-1:0]     signL;
  logic [WC*M-1:0]   absL;
  logic [WC*W-1:0]   L;
  logic              in_valid2, in_ready2, out_valid2, out_ready2, nz_flag2;
  logic [WC*W-1:0]   L2;

  int                nvec  = 0;
  int                nfail = 0;
  logic [WC*W:0]     sb[$];
  logic [WC*W:0]     mon_exp;

  always #5 clk = ~clk;

  sign_mag_combiner #(.W(W), .Wc(WC), .P(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signL(signL), .absL(absL), .out_valid(out_valid), .out_ready(out_ready),
    .L(L), .nz_flag(nz_flag)
  );

  sign_mag_combiner #(.W(W), .Wc(WC), .P(18)) dut18 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .signL(signL), .absL(absL), .out_valid(out_valid2), .out_ready(out_ready2),
    .L(L2), .nz_flag(nz_flag2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WC*W:0] model(input logic [WC-1:0] s, input logic [WC*M-1:0] a);
    logic [WC*W-1:0] l;
    logic            nz;
    logic [M-1:0]    m;
    int              v;
    l  = '0;
    nz = 1'b0;
    for (int i = 0; i < WC; i++) begin
      m = a[i*M +: M];
      v = s[i] ? -int'(m) : int'(m);
      l[i*W +: W] = v[W-1:0];
      if (s[i] && m == 0) nz = 1'b1;
    end
    return {nz, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WC-1:0] s, input logic [WC*M-1:0] a, output int waited);
    in_valid = 1'b1;
    signL    = s;
    absL     = a;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("accept_in_ready", in_ready, 1'b1);
    sb.push_back(model(s, a));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic rand_frame(input int tagv, output logic [WC-1:0] s, output logic [WC*M-1:0] a);
    s = WC'($urandom);
    for (int i = 0; i < WC; i++) a[i*M +: M] = M'($urandom_range(0, 31));
    a[M-1:0] = M'(tagv + 1);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $error("FAIL sb_unexpected: observed frame %0h, expected no frame", L);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_L", L, mon_exp[WC*W-1:0]);
        check("sb_nz", nz_flag, mon_exp[WC*W]);
      end
    end
  end

  initial begin
    logic [WC-1:0]   s1, s;
    logic [WC*M-1:0] a1, a;
    logic [WC*W-1:0] e1, e, snap;
    logic [WC*W:0]   mref;
    int              waited, cyc, bound;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; signL = '0; absL = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready_low", in_ready, 1'b0);
    check("rst_L", L, '0);
    check("rst_nz", nz_flag, 1'b0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    tick();

    // basic values
    s1 = '0; a1 = '0;
    a1[0*M +: M] = 5'd13;
    s1[1] = 1'b1; a1[1*M +: M] = 5'd1;
    s1[17] = 1'b1; a1[17*M +: M] = 5'd31;
    e1 = '0;
    e1[0*W +: W] = 6'b001101;
    e1[1*W +: W] = 6'b111111;
    e1[17*W +: W] = 6'b100001;
    send_frame(s1, a1, waited);
    wait_out(cyc);
    check("basic_latency", cyc, 3);
    check("basic_L", L, e1);
    check("basic_nz", nz_flag, 1'b0);

    // negative zero
    s = '0;
    for (int i = 0; i < WC; i++) a[i*M +: M] = 5'd5;
    s[9] = 1'b1; a[9*M +: M] = 5'd0;
    e = '0;
    for (int i = 0; i < WC; i++) e[i*W +: W] = 6'b000101;
    e[9*W +: W] = 6'b000000;
    send_frame(s, a, waited);
    check("nz_overlap_wait", waited, 0);
    wait_out(cyc);
    check("nz_latency", cyc, 3);
    check("nz_L", L, e);
    check("nz_flag", nz_flag, 1'b1);

    // backpressure
    out_ready = 1'b0;
    snap = L;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_L_stable", L, snap);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    rand_frame(7, s, a);
    signL = s;
    absL = a;
    #1;
    check("bp_release_valid", out_valid, 1'b1);
    send_frame(s, a, waited);
    check("bp_same_cycle_accept", waited, 0);
    wait_out(cyc);
    check("bp_latency", cyc, 3);
    mref = model(s, a);
    check("bp_L", L, mref[WC*W-1:0]);

    // streaming with in_valid and out_ready held high
    for (int k = 0; k < 4; k++) begin
      rand_frame(k + 20, s, a);
      send_frame(s, a, waited);
      if (k > 0) check("stream_interval", waited + 1, 4);
    end
    bound = 0;
    while (sb.size() != 0 && bound < 30) begin
      tick();
      bound++;
    end
    check("stream_drained", sb.size(), 0);

    // reset during the second CONV cycle
    s = '1;
    for (int i = 0; i < WC; i++) a[i*M +: M] = M'(i + 3);
    a[0*M +: M] = 5'd0;
    send_frame(s, a, waited);
    tick();
    rst = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_L", L, '0);
    check("mid_rst_nz", nz_flag, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    s = WC'($urandom);
    for (int i = 0; i < WC; i++) a[i*M +: M] = M'($urandom_range(1, 31));
    send_frame(s, a, waited);
    wait_out(cyc);
    check("post_rst_latency", cyc, 3);
    mref = model(s, a);
    check("post_rst_L", L, mref[WC*W-1:0]);
    check("post_rst_nz", nz_flag, 1'b0);
    tick();
    tick();

    // single-group build
    signL = s1;
    absL = a1;
    in_valid2 = 1'b1;
    #1;
    check("p18_in_ready", in_ready2, 1'b1);
    tick();
    in_valid2 = 1'b0;
    check("p18_not_yet", out_valid2, 1'b0);
    tick();
    check("p18_out_valid", out_valid2, 1'b1);
    check("p18_L", L2, e1);
    check("p18_nz", nz_flag2, 1'b0);
    tick();
    check("p18_idle", out_valid2, 1'b0);

    check("sb_final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sign_mag_combiner.md
# sign_mag_combiner

- Converts a frame of Wc sign/magnitude pairs back into Wc two's-complement W-bit LLR values.
- It is the inverse of the absolute/sign split done at the check-node input.
- It sits at the check-node output of the min-sum decoder, ahead of the variable-node update.
- It converts P lanes per cycle over Wc/P cycles and exchanges frames through valid/ready handshakes on both sides.

## Interface
Clock: one clock. Reset: asynchronous, active-low.

Parameters:
- W, 6: width of each two's-complement output value; magnitudes are W-1 bits.
- Wc, 18: lanes per frame (check-node degree).
- P, 6: lanes converted per cycle. Wc % P must be 0; P = Wc is legal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  a frame is present on signL/absL.
- in_ready  output  1  block accepts a frame this cycle.
- signL  input  Wc  sign per lane; bit i belongs to lane i; 1 = negative.
- absL  input  Wc*(W-1)  magnitudes; lane i occupies bits [(i+1)(W-1)-1 : i(W-1)].
- out_valid  output  1  L and nz_flag hold a complete frame.
- out_ready  input  1  consumer accepts the frame this cycle.
- L  output  Wc*W  two's-complement values; lane i occupies bits [(i+1)W-1 : iW].
- nz_flag  output  1  at least one lane of the frame had sign=1 with magnitude 0.

## Operation
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid, signL/absL are captured into internal registers, grp counter is set to 0, the nz accumulator is cleared, and the FSM goes to CONV.
- CONV:
  - in_ready=0.
  - Each cycle converts lanes grp*P … grp*P+P-1 and writes them into L.
  - nz accumulator |= negative-zero of those lanes.
  - grp increments each cycle. When grp = Wc/P-1, the last group is written, nz_flag is loaded from the accumulator, and the FSM goes to HOLD.
- HOLD:
  - out_valid=1; L and nz_flag are stable.
  - in_ready = out_ready.
  - On out_ready=1 with in_valid=1, the frame is released and the new frame is captured in the same cycle; the FSM goes to CONV.
  - On out_ready=1 with in_valid=0, the FSM goes to IDLE.
  - On out_ready=0, the FSM stays in HOLD.
- Lane conversion, with m = magnitude and s = sign:
  - s=0: result = {1'b0, m}.
  - s=1, m≠0: result = two's-complement negation of {1'b0, m}, computed in W bits. It never overflows, since |value| ≤ 2^(W-1)-1.
  - s=1, m=0: result = 0. This case marks the lane as negative-zero.
- L contents are defined only while out_valid=1. Lanes are overwritten group by group during CONV.
- Captured inputs are held internally, so signL/absL may change freely after the accepting cycle.
- Reset, at any time including mid-frame, forces all of the following:
  - FSM to IDLE and grp to 0.
  - L, nz_flag and the capture registers to 0.
  - out_valid to 0 and in_ready to 0 while rst is low; in_ready=1 from the first cycle after release.
  - Any partial frame is discarded.

## Timing
- Let N = Wc/P (3 at the default parameters).
- The frame is accepted at edge 0 (in_valid & in_ready). Lane groups are written at edges 1…N. out_valid=1 from just after edge N.
- Latency: N cycles from acceptance to out_valid.
- Throughput with out_ready held at 1: one frame every N+1 cycles. The HOLD-state accept overlaps the release.
- out_valid, once high, stays high until the cycle with out_ready=1, and L must not change before then.
- in_ready is combinational from state and out_ready. No other output depends combinationally on inputs.
- P = Wc: N=1. The frame is converted in a single CONV cycle, and out_valid asserts one cycle after acceptance.

## Test plan
All cases use the default parameters W=6, Wc=18, P=6.
- Reset and basic values:
  - After reset: out_valid=0, L=0, nz_flag=0, in_ready=1.
  - Then send one frame with lane0 s=0,m=13 / lane1 s=1,m=1 / lane17 s=1,m=31 and all others s=0,m=0.
  - Required: out_valid exactly 3 cycles after acceptance; lane0=6'b001101, lane1=6'b111111, lane17=6'b100001, others 0; nz_flag=0.
- Negative zero: lane9 s=1,m=0 and all others s=0,m=5. Required: lane9=0, others 6'b000101, nz_flag=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid. Required: L/out_valid stable and in_ready=0 throughout.
  - Then set out_ready=1 with in_valid=1 and a new frame. Required: the new frame is captured that cycle and its result appears 3 cycles later.
- Streaming: in_valid and out_ready held at 1, with 4 distinct random frames. Required: one output every 4 cycles; every lane matches the reference conversion.
- Reset mid-frame: assert rst during the second CONV cycle. Required: out_valid=0 and L=0 immediately; in_ready=1 after release; the next frame converts correctly, with no residue from the aborted frame and nz_flag cleared.
- Parameter variant P=18: the frame converts in 1 cycle and out_valid asserts the cycle after acceptance; values match the default-parameter results.
